// File: rtl/trig_alignment_monitor.sv
// Per-VFAT lock supervisor behind the trigger frame aligner: gates S-bits on lock,
// tracks lock state, counts lock losses / realigns and pulses an aligner realign request.
module trig_alignment_monitor #(
    parameter int unsigned MXSBITS       = 64,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned HOLDOFF_WIDTH = 12
) (
    input  logic                     clock,
    input  logic                     reset_i,
    input  logic [MXSBITS-1:0]       sbits_i,
    input  logic                     sot_is_aligned_i,
    input  logic                     sot_unstable_i,
    input  logic                     mask_i,
    input  logic                     auto_realign_en_i,
    input  logic [HOLDOFF_WIDTH-1:0] realign_holdoff_i,
    input  logic                     cnt_reset_i,
    output logic [MXSBITS-1:0]       sbits_o,
    output logic                     sbits_valid_o,
    output logic [1:0]               state_o,
    output logic                     realign_req_o,
    output logic [CNT_WIDTH-1:0]     lock_loss_cnt_o,
    output logic [CNT_WIDTH-1:0]     realign_cnt_o
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_LOCKED   = 2'd1;
    localparam logic [1:0] ST_UNSTABLE = 2'd2;
    localparam logic [1:0] ST_REALIGN  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [1:0]               state_q, state_d;
    logic [HOLDOFF_WIDTH-1:0] holdoff_q, holdoff_d;
    logic [CNT_WIDTH-1:0]     lock_loss_q, lock_loss_d;
    logic [CNT_WIDTH-1:0]     realign_cnt_q, realign_cnt_d;
    logic [MXSBITS-1:0]       sbits_q, sbits_d;
    logic                     valid_q, valid_d;
    logic                     req_q, req_d;
    logic                     stable_c;
    logic                     lock_loss_c;

    assign stable_c = sot_is_aligned_i && !sot_unstable_i;

    // State, holdoff and output registers
    always_ff @(posedge clock or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= ST_UNLOCKED;
            holdoff_q     <= '0;
            lock_loss_q   <= '0;
            realign_cnt_q <= '0;
            sbits_q       <= '0;
            valid_q       <= 1'b0;
            req_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            holdoff_q     <= holdoff_d;
            lock_loss_q   <= lock_loss_d;
            realign_cnt_q <= realign_cnt_d;
            sbits_q       <= sbits_d;
            valid_q       <= valid_d;
            req_q         <= req_d;
        end
    end

    // Next-state, gating and counter logic
    always_comb begin
        state_d       = state_q;
        holdoff_d     = holdoff_q;
        req_d         = 1'b0;
        lock_loss_c   = 1'b0;
        valid_d       = (state_q == ST_LOCKED) && stable_c && !mask_i;
        sbits_d       = valid_d ? sbits_i : '0;
        lock_loss_d   = lock_loss_q;
        realign_cnt_d = realign_cnt_q;

        case (state_q)
            ST_UNLOCKED: begin
                if (stable_c && !mask_i) state_d = ST_LOCKED;
            end
            ST_LOCKED: begin
                if (mask_i) begin
                    state_d = ST_UNLOCKED;
                end else if (!stable_c) begin
                    state_d     = ST_UNSTABLE;
                    lock_loss_c = 1'b1;
                end
            end
            ST_UNSTABLE: begin
                if (mask_i) begin
                    state_d = ST_UNLOCKED;
                end else if (auto_realign_en_i) begin
                    state_d   = ST_REALIGN;
                    req_d     = 1'b1;
                    holdoff_d = realign_holdoff_i;
                end else if (stable_c) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_REALIGN: begin
                if (mask_i) begin
                    state_d = ST_UNLOCKED;
                end else if (holdoff_q != '0) begin
                    holdoff_d = holdoff_q - HOLDOFF_WIDTH'(1);
                end else begin
                    state_d = ST_UNLOCKED;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase

        // Saturating counters; a clear beats a same-cycle increment
        if (cnt_reset_i) begin
            lock_loss_d   = '0;
            realign_cnt_d = '0;
        end else begin
            if (lock_loss_c && lock_loss_q != CNT_MAX) lock_loss_d = lock_loss_q + CNT_WIDTH'(1);
            if (req_d && realign_cnt_q != CNT_MAX) realign_cnt_d = realign_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign sbits_o         = sbits_q;
    assign sbits_valid_o   = valid_q;
    assign state_o         = state_q;
    assign realign_req_o   = req_q;
    assign lock_loss_cnt_o = lock_loss_q;
    assign realign_cnt_o   = realign_cnt_q;

endmodule
